// File: rtl/ice40_accum_chain.sv
// Registered WIDTH-bit load/add/subtract accumulator built on a ripple chain of
// LUT4(16'h9696)+CARRY full-adder cells. Define ICE40_ACCUM_SAT_EN to clamp on signed overflow.
module ice40_accum_chain #(
    parameter int          WIDTH = 8,              // legal range 2..32
    parameter logic [31:0] INIT  = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] I,
    input  logic             CIN,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             Z,
    output logic             OVF
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_ADD  = 2'b10,
        MODE_SUB  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] INIT_C   = INIT[WIDTH-1:0];
    localparam logic [15:0]      LUT_INIT = 16'h9696;

    // SB_LUT4 truth-table lookup; with I3 tied low, 16'h9696 is a 3-input XOR.
    function automatic logic sb_lut4(input logic [15:0] init, input logic i0, input logic i1,
                                     input logic i2, input logic i3);
        return init[{i3, i2, i1, i0}];
    endfunction

    // SB_CARRY: majority of the two operands and the incoming carry.
    function automatic logic sb_carry(input logic i0, input logic i1, input logic ci);
        return (i0 & i1) | ((i0 | i1) & ci);
    endfunction

    logic [WIDTH-1:0] acc_r;
    logic             cout_r;
    logic             z_r;
    logic             ovf_r;

    logic             is_sub_s;
    logic [WIDTH-1:0] op_b_s;
    logic             chain_cin_s;
    logic [WIDTH-1:0] sum_s;
    logic             carry_msb_in_s;
    logic             carry_out_s;
    logic             ovf_v_s;
    logic [WIDTH-1:0] arith_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             cout_next_s;
    logic             ovf_next_s;

    assign is_sub_s = (MODE == MODE_SUB);

    // Fabric inversion of operand and carry-in ahead of the chain for subtraction.
    always_comb begin
        if (is_sub_s) begin
            op_b_s      = ~I;
            chain_cin_s = ~CIN;
        end else begin
            op_b_s      = I;
            chain_cin_s = CIN;
        end
    end

    // Ripple chain of WIDTH full-adder cells between the accumulator and its next state.
    always_comb begin : chain_comb
        logic [WIDTH:0] c_v;
        c_v[0] = chain_cin_s;
        for (int i = 0; i < WIDTH; i++) begin
            sum_s[i]  = sb_lut4(LUT_INIT, acc_r[i], op_b_s[i], c_v[i], 1'b0);
            c_v[i+1]  = sb_carry(acc_r[i], op_b_s[i], c_v[i]);
        end
        carry_msb_in_s = c_v[WIDTH-1];
        carry_out_s    = c_v[WIDTH];
    end

    assign ovf_v_s = carry_msb_in_s ^ carry_out_s;

`ifdef ICE40_ACCUM_SAT_EN
    // Clamp to the signed limit; a set sum MSB on overflow means the true result was positive.
    always_comb begin
        if (ovf_v_s) begin
            if (sum_s[WIDTH-1]) begin
                arith_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                arith_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            arith_s = sum_s;
        end
    end
`else
    // Plain two's-complement wrap.
    always_comb begin
        arith_s = sum_s;
    end
`endif

    // Next-state selection by operation mode.
    always_comb begin
        acc_next_s  = acc_r;
        cout_next_s = cout_r;
        ovf_next_s  = ovf_r;
        case (mode_e'(MODE))
            MODE_HOLD: begin
                acc_next_s  = acc_r;
                cout_next_s = cout_r;
                ovf_next_s  = ovf_r;
            end
            MODE_LOAD: begin
                acc_next_s  = I;
                cout_next_s = 1'b0;
                ovf_next_s  = 1'b0;
            end
            MODE_ADD, MODE_SUB: begin
                acc_next_s  = arith_s;
                cout_next_s = carry_out_s;
                ovf_next_s  = ovf_r | ovf_v_s;
            end
            default: begin
                acc_next_s  = acc_r;
                cout_next_s = cout_r;
                ovf_next_s  = ovf_r;
            end
        endcase
    end

    // State registers; reset wins over enable, Z tracks the value being written to O.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_r  <= INIT_C;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            z_r    <= (INIT_C == {WIDTH{1'b0}});
        end else if (EN) begin
            acc_r  <= acc_next_s;
            cout_r <= cout_next_s;
            ovf_r  <= ovf_next_s;
            z_r    <= (acc_next_s == {WIDTH{1'b0}});
        end
    end

    assign O    = acc_r;
    assign COUT = cout_r;
    assign Z    = z_r;
    assign OVF  = ovf_r;

endmodule

// File: tb/tb_ice40_accum_chain.sv
// Scoreboard bench for ice40_accum_chain (WIDTH=8, INIT=8'h05): an arithmetic reference
// model queues expected state per issued cycle; a monitor pops and compares after each edge.
module tb_ice40_accum_chain;

    localparam int WIDTH = 8;
    localparam int FULL  = 1 << WIDTH;
    localparam int HALF  = 1 << (WIDTH - 1);
    localparam int INIT  = 8'h05;

    typedef struct {
        int o;
        int cout;
        int z;
        int ovf;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] i_op;
    logic             cin;
    logic [WIDTH-1:0] o;
    logic             cout;
    logic             z;
    logic             ovf;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state as plain integers.
    int m_acc  = 0;
    int m_cout = 0;
    int m_ovf  = 0;

    ice40_accum_chain #(.WIDTH(WIDTH), .INIT(32'(INIT))) dut (
        .CLK(clk), .RESET(reset), .EN(en), .MODE(mode), .I(i_op), .CIN(cin),
        .O(o), .COUT(cout), .Z(z), .OVF(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Apply one arithmetic result (exact integer) to the model.
    task automatic apply_arith(input int exact_u, input int exact_s, input int no_carry_out);
        int ovf_now;
        ovf_now = (exact_s > HALF - 1) || (exact_s < -HALF);
        m_cout  = no_carry_out;
`ifdef ICE40_ACCUM_SAT_EN
        if (ovf_now != 0) m_acc = (exact_s > 0) ? HALF - 1 : HALF;
        else              m_acc = ((exact_u % FULL) + FULL) % FULL;
`else
        m_acc = ((exact_u % FULL) + FULL) % FULL;
`endif
        m_ovf = m_ovf | ovf_now;
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input int iv, input logic ci);
        exp_t ex;
        int   sa;
        int   si;
        @(negedge clk);
        reset = r; en = e; mode = md; i_op = WIDTH'(iv); cin = ci;
        sa = to_signed(m_acc);
        si = to_signed(iv);
        if (r) begin
            m_acc = INIT; m_cout = 0; m_ovf = 0;
        end else if (e) begin
            case (md)
                2'b01: begin m_acc = iv; m_cout = 0; m_ovf = 0; end
                2'b10: apply_arith(m_acc + iv + int'(ci), sa + si + int'(ci),
                                   int'((m_acc + iv + int'(ci)) >= FULL));
                2'b11: apply_arith(m_acc - iv - int'(ci), sa - si - int'(ci),
                                   int'((m_acc - iv - int'(ci)) >= 0));
                default: ;
            endcase
        end
        ex.o = m_acc; ex.cout = m_cout; ex.z = int'(m_acc == 0); ex.ovf = m_ovf;
        exp_q.push_back(ex);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every edge presents a new state, compared against the oldest queued entry.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("O",    int'(o),    ex.o);
                check("COUT", int'(cout), ex.cout);
                check("Z",    int'(z),    ex.z);
                check("OVF",  int'(ovf),  ex.ovf);
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b00; i_op = '0; cin = 1'b0;

        // Reset and enable gating.
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'b10, 8'h10, 1'b0);
        // LOAD then ADD to zero with carry-in.
        step(1'b0, 1'b1, 2'b01, 8'hFE, 1'b0);
        step(1'b0, 1'b1, 2'b10, 8'h01, 1'b1);
        // Positive signed overflow, sticky through HOLD, cleared by LOAD.
        step(1'b0, 1'b1, 2'b01, 8'h7F, 1'b0);
        step(1'b0, 1'b1, 2'b10, 8'h01, 1'b0);
        step(1'b0, 1'b1, 2'b00, 8'h33, 1'b1);
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
        // SUB with borrow-in, then borrow-out.
        step(1'b0, 1'b1, 2'b01, 8'h10, 1'b0);
        step(1'b0, 1'b1, 2'b11, 8'h03, 1'b1);
        step(1'b0, 1'b1, 2'b11, 8'h0D, 1'b0);
        // Negative signed overflow.
        step(1'b0, 1'b1, 2'b01, 8'h80, 1'b0);
        step(1'b0, 1'b1, 2'b11, 8'h01, 1'b0);
        // Wrap-around both ways.
        step(1'b0, 1'b1, 2'b01, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 2'b10, 8'h01, 1'b0);
        step(1'b0, 1'b1, 2'b11, 8'h01, 1'b0);
        // Reset mid-sequence overrides an in-flight ADD.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'b10, 8'h01, 1'b0);
        step(1'b1, 1'b1, 2'b10, 8'h01, 1'b0);
        step(1'b0, 1'b1, 2'b10, 8'h01, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, FULL - 1)),
                 1'($urandom_range(0, 1)));
        end

        // Drain with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
